// File: rtl/cos_arg_reduce.sv
// Cosine argument range reduction: mod 2*pi by shift-subtract, then fold to [0, pi/2].
// Optional COS_ARG_SIGNED_EN: accept two's-complement angles via cos(-x) = cos(x).
module cos_arg_reduce (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a_in,
  input  logic [8:0]  y_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] x_out,
  output logic [8:0]  y_out,
  output logic        neg,
  output logic [1:0]  quad,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [15:0] TWO_PI  = 16'h0649;
  localparam logic [15:0] PI      = 16'h0324;
  localparam logic [15:0] HALF_PI = 16'h0192;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    FOLD,
    OUT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] areg_q, areg_d;
  logic [8:0]  yreg_q, yreg_d;
  logic [2:0]  k_q, k_d;
  logic [15:0] x_out_q, x_out_d;
  logic [8:0]  y_out_q, y_out_d;
  logic        neg_q, neg_d;
  logic [1:0]  quad_q, quad_d;
  logic        out_valid_q, out_valid_d;

  logic [15:0] a_mag;
  logic [15:0] step_c;
  logic [15:0] t_c;
  logic [15:0] x_c;
  logic        q1_c;
  logic        q0_c;

`ifdef COS_ARG_SIGNED_EN
  assign a_mag = a_in[15] ? (~a_in + 16'd1) : a_in;
`else
  assign a_mag = a_in;
`endif

  always_comb begin
    step_c = TWO_PI << k_q;
    q1_c   = areg_q >= PI;
    t_c    = q1_c ? (areg_q - PI) : areg_q;
    q0_c   = t_c > HALF_PI;
    x_c    = q0_c ? (PI - t_c) : t_c;
  end

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    areg_d      = areg_q;
    yreg_d      = yreg_q;
    k_d         = k_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    neg_d       = neg_q;
    quad_d      = quad_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          areg_d  = a_mag;
          yreg_d  = y_in;
          k_d     = 3'd5;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (areg_q >= step_c) begin
          areg_d = areg_q - step_c;
        end
        k_d = k_q - 3'd1;
        if (k_q == 3'd0) begin
          state_d = FOLD;
        end
      end
      FOLD: begin
        x_out_d     = x_c;
        y_out_d     = yreg_q;
        neg_d       = q1_c ^ q0_c;
        quad_d      = {q1_c, q0_c};
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      areg_q      <= '0;
      yreg_q      <= '0;
      k_q         <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      neg_q       <= 1'b0;
      quad_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      areg_q      <= areg_d;
      yreg_q      <= yreg_d;
      k_q         <= k_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      neg_q       <= neg_d;
      quad_q      <= quad_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign neg       = neg_q;
  assign quad      = quad_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cos_arg_reduce.sv
// Self-checking bench for cos_arg_reduce: directed table, corner sequences,
// and randomized angles against an arithmetic mod-2pi / fold model.
module tb_cos_arg_reduce;

  logic        clk;
  logic        rst;
  logic [15:0] a_in;
  logic [8:0]  y_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_out;
  logic [8:0]  y_out;
  logic        neg;
  logic [1:0]  quad;
  logic        out_valid;
  logic        out_ready;

  int n_pass;
  int n_total;

  cos_arg_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .neg       (neg),
    .quad      (quad),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [8:0]  y;
    logic [15:0] x;
    logic        n;
    logic [1:0]  q;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Angle mod 2pi by plain remainder, then fold into the first quadrant.
  task automatic model(input logic [15:0] a, output logic [15:0] x,
                       output logic n, output logic [1:0] q);
    int m;
    int t;
    bit q1;
    bit q0;
    m = int'(a);
`ifdef COS_ARG_SIGNED_EN
    if (a[15]) m = 65536 - int'(a);
`endif
    m  = m % 1609;
    q1 = (m >= 804);
    t  = q1 ? m - 804 : m;
    q0 = (t > 402);
    x  = 16'(q0 ? 804 - t : t);
    n  = q1 ^ q0;
    q  = {q1, q0};
  endtask

  task automatic send(input logic [15:0] a, input logic [8:0] y);
    int w;
    w = 0;
    while (!in_ready && w < 30) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    a_in     = a;
    y_in     = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in     = 16'hDEAD;
    y_in     = 9'h155;
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, 7);
  endtask

  task automatic run_vec(input string name, input vec_t v, input int hold);
    int lat;
    send(v.a, v.y);
    chk({name, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    wait_out(name, lat);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_x_out"}, {16'd0, x_out}, {16'd0, v.x});
    chk({name, "_y_out"}, {23'd0, y_out}, {23'd0, v.y});
    chk({name, "_neg"},   {31'd0, neg},   {31'd0, v.n});
    chk({name, "_quad"},  {30'd0, quad},  {30'd0, v.q});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  vec_t tbl[6];

  initial begin
    vec_t v;
    int   lat;
    logic [15:0] hx;
    logic [8:0]  hy;
    logic        hn;
    logic [1:0]  hq;
    bit          stable;
    bit          seen;

    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    a_in      = '0;
    y_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    tbl[0] = '{16'h0000, 9'h010, 16'h0000, 1'b0, 2'd0};
    tbl[1] = '{16'h0324, 9'h0A5, 16'h0000, 1'b1, 2'd2};
    tbl[2] = '{16'h0649, 9'h1FF, 16'h0000, 1'b0, 2'd0};
    tbl[3] = '{16'h0200, 9'h003, 16'h0124, 1'b1, 2'd1};
    tbl[4] = '{16'hFFFF, 9'h100, 16'h0173, 1'b1, 2'd2};
`ifdef COS_ARG_SIGNED_EN
    tbl[5] = '{16'hFE00, 9'h07E, 16'h0124, 1'b1, 2'd1};
`else
    tbl[5] = '{16'hFE00, 9'h07E, 16'h008C, 1'b1, 2'd1};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_outputs",
        {x_out, 4'd0, y_out, neg, quad}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("tbl%0d", i), tbl[i], 0);
    end

    // Backpressure: outputs frozen, no new input taken while held.
    v = tbl[3];
    send(v.a, v.y);
    wait_out("bp", lat);
    hx = x_out; hy = y_out; hn = neg; hq = quad;
    in_valid = 1'b1;
    a_in     = 16'h0100;
    for (int c = 0; c < 10; c++) begin
      stable = out_valid && x_out == v.x && y_out == v.y &&
               neg == v.n && quad == v.q && !in_ready;
      chk($sformatf("bp_hold%0d", c), {31'd0, stable}, 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("bp_ready_back", {31'd0, in_ready},  32'd1);
    v = '{16'h0649, 9'h0AA, 16'h0000, 1'b0, 2'd0};
    run_vec("bp_next", v, 0);

    // Reset mid-REDUCE discards the transaction.
    send(16'h0200, 9'h033);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_mid_outputs",   {x_out, 4'd0, y_out, neg, quad}, 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_no_stale", {31'd0, seen}, 32'd0);

    // Reset while a result is being held.
    send(16'h0200, 9'h044);
    wait_out("rst_out", lat);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_x",     {16'd0, x_out},     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      v.a = 16'($urandom);
      v.y = 9'($urandom);
      if (i == 0) v.a = 16'h8000;
      model(v.a, v.x, v.n, v.q);
      run_vec($sformatf("rnd%0d_a%04h", i, v.a), v, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cos_arg_reduce.md
# cos_arg_reduce

Range-reduction front end for the cosine datapath. It accepts one Q8.8 angle in radians plus the 9-bit termination threshold, and reduces the angle modulo 2π. It then folds the result into [0, π/2] and presents the reduced argument, a result-negate flag and the quadrant to the cosine series stage through a valid/ready handshake. It sits directly upstream of the cosine series datapath: `x_out` drives that stage's `xin`, and `y_out` drives its `y`.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `a_in`  in  16  angle, Q8.8 radians; unsigned unless `COS_ARG_SIGNED_EN` is defined.
- `y_in`  in  9  series termination threshold; passed through unchanged.
- `in_valid`  in  1  `a_in` / `y_in` are valid.
- `in_ready`  out  1  block can accept an input; high only in IDLE.
- `x_out`  out  16  reduced argument, Q8.8, range 0..0x0192.
- `y_out`  out  9  registered copy of `y_in`.
- `neg`  out  1  downstream result must be negated.
- `quad`  out  2  quadrant of the reduced angle: 0 = [0,π/2], 1 = (π/2,π), 2 = [π,3π/2], 3 = (3π/2,2π).
- `out_valid`  out  1  `x_out` / `y_out` / `neg` / `quad` are valid.
- `out_ready`  in  1  downstream accepts the result.

## Operation
- Constants (Q8.8, truncated/rounded, fixed): TWO_PI = 0x0649 (1609), PI = 0x0324 (804), HALF_PI = 0x0192 (402).
- Internal state: 16-bit `areg`, 9-bit `yreg`, 3-bit step counter `k`.
- FSM states and transitions:
  - IDLE → REDUCE on `in_valid && in_ready`. On that edge: `areg <= a_in`, `yreg <= y_in`, `k <= 5`.
  - REDUCE: each cycle, if `areg >= (TWO_PI << k)` then `areg <= areg - (TWO_PI << k)`. All shifted constants fit in 16 bits (max 51488). `k` decrements each cycle; after the k = 0 step, go to FOLD. Exactly 6 cycles. Result: `areg` in [0, 1608].
  - FOLD (one cycle):
    - `q1 = areg >= PI`; `t = q1 ? areg - PI : areg`.
    - `q0 = t > HALF_PI`; `x = q0 ? PI - t : t`.
    - Load `x_out <= x`, `y_out <= yreg`, `neg <= q1 ^ q0`, `quad <= {q1, q0}`, `out_valid <= 1`. Go to OUT.
  - OUT: hold all outputs stable while `out_ready` = 0. On `out_valid && out_ready`: `out_valid <= 0`, go to IDLE.
- Arithmetic is unsigned 16-bit throughout; no subtraction ever underflows.
- Truncation error: TWO_PI is about 0.5 LSB high, so the reduced angle carries up to 20 LSB of accumulated error at the top of the input range. This is accepted.
- Only one transaction is in flight. No input is accepted in REDUCE, FOLD or OUT.

## Timing
- Reset values: `in_ready` = 1 (state IDLE); `out_valid` = 0; `x_out` = 0; `y_out` = 0; `neg` = 0; `quad` = 0; `areg` = 0; `k` = 0.
- Input handshake at edge N → `out_valid` rises after edge N+7. Latency is 7 cycles, fixed and data-independent.
- `in_ready` is combinational from the state and is low from edge N until the edge after the output handshake.
- The earliest the next input can be accepted is the cycle after the output handshake, so the minimum issue interval is 9 cycles.
- `rst` asserted at any point, including mid-REDUCE or OUT with `out_valid` high: all registers clear immediately and the in-flight transaction is discarded, with no output.
- `in_valid` outside IDLE is ignored; the upstream must hold its data.

## Configuration
- `COS_ARG_SIGNED_EN` defined:
  - `a_in` is two's-complement Q8.8.
  - On the load edge, `areg <= (a_in[15] ? -a_in : a_in)`, taken as an unsigned 16-bit magnitude. 0x8000 loads as 32768. This uses cos(−x) = cos(x).
  - Latency is unchanged.
- `COS_ARG_SIGNED_EN` undefined: `a_in` is loaded unsigned as-is, and there is no negation logic.

## Test plan
- Reset, then `a_in` = 0x0000, `y_in` = 0x010 → after 7 cycles: `x_out` = 0x0000, `neg` = 0, `quad` = 0, `y_out` = 0x010.
- `a_in` = 0x0324 (π) → `x_out` = 0x0000, `neg` = 1, `quad` = 2. `a_in` = 0x0649 (2π) → `x_out` = 0x0000, `neg` = 0, `quad` = 0.
- `a_in` = 0x0200 (2.0 rad) → `x_out` = 0x0124, `neg` = 1, `quad` = 1. `a_in` = 0xFFFF → `x_out` = 0x0173, `neg` = 1, `quad` = 2.
- Backpressure: hold `out_ready` = 0 for 10 cycles after `out_valid` rises → outputs stable and `in_ready` = 0 throughout. Then a 1-cycle `out_ready` → `out_valid` falls, `in_ready` = 1 next cycle, and a new input is accepted.
- Assert `rst` 3 cycles into REDUCE → `out_valid` = 0, `in_ready` = 1 and all outputs 0 immediately. No stale result appears afterwards.
- `a_in` = 0xFE00:
  - With `COS_ARG_SIGNED_EN` → `x_out` = 0x0124, `neg` = 1, `quad` = 1.
  - Without it → `x_out` = 0x008C, `neg` = 1, `quad` = 1.
